// File: rtl/adc_sine_monitor.sv
// Midscale-crossing period, peak/trough and lock monitor for an 8-bit offset-binary ADC stream.
// Rising crossings use hysteresis; lock is declared after LOCK_COUNT consecutive stable periods.
module adc_sine_monitor #(
    parameter int unsigned MID        = 128,
    parameter int unsigned HYST       = 4,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned TOL        = 2,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_valid,
    input  logic [7:0]       sample,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period,
    output logic [7:0]       peak,
    output logic [7:0]       trough,
    output logic [7:0]       amplitude,
    output logic             locked,
    output logic             timeout
);

    localparam logic [7:0]       ARM_LVL     = 8'(MID - HYST);
    localparam logic [7:0]       CROSS_LVL   = 8'(MID + HYST);
    localparam int unsigned      LC_W        = $clog2(LOCK_COUNT + 1);
    localparam logic [LC_W-1:0]  LOCK_MAX    = LC_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TOL_CNT     = CNT_W'(TOL);

    typedef enum logic [1:0] {
        SEEK_ARM0   = 2'd0,
        SEEK_CROSS0 = 2'd1,
        SEEK_ARM    = 2'd2,
        SEEK_CROSS  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       min_q, min_d;
    logic [7:0]       max_q, max_d;
    logic [LC_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic             have_prev_q, have_prev_d;
    logic [CNT_W-1:0] prev_period_q, prev_period_d;
    logic             meas_valid_q, meas_valid_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [7:0]       peak_q, peak_d;
    logic [7:0]       trough_q, trough_d;
    logic [7:0]       amplitude_q, amplitude_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;

    logic             is_arm;
    logic             is_cross;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] period_diff;
    logic [LC_W-1:0]  lock_cnt_meas;

    assign is_arm   = (sample <= ARM_LVL);
    assign is_cross = (sample >= CROSS_LVL);
    assign cnt_inc  = cnt_q + CNT_W'(1);

    // Stability of the period just ended against the previous one.
    always_comb begin
        period_diff   = (cnt_q >= prev_period_q) ? (cnt_q - prev_period_q)
                                                 : (prev_period_q - cnt_q);
        lock_cnt_meas = LC_W'(1);
        if (!have_prev_q || (period_diff <= TOL_CNT)) begin
            lock_cnt_meas = (lock_cnt_q >= LOCK_MAX) ? LOCK_MAX : (lock_cnt_q + LC_W'(1));
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        min_d         = min_q;
        max_d         = max_q;
        lock_cnt_d    = lock_cnt_q;
        have_prev_d   = have_prev_q;
        prev_period_d = prev_period_q;
        meas_valid_d  = 1'b0;
        period_d      = period_q;
        peak_d        = peak_q;
        trough_d      = trough_q;
        amplitude_d   = amplitude_q;
        locked_d      = locked_q;
        timeout_d     = 1'b0;

        if (sample_valid) begin
            unique case (state_q)
                SEEK_ARM0: begin
                    if (is_arm) state_d = SEEK_CROSS0;
                end
                SEEK_CROSS0: begin
                    if (is_cross) begin
                        cnt_d   = CNT_W'(1);
                        min_d   = sample;
                        max_d   = sample;
                        state_d = SEEK_ARM;
                    end
                end
                SEEK_ARM, SEEK_CROSS: begin
                    if ((state_q == SEEK_CROSS) && is_cross) begin
                        // Window closes before this sample; it opens the next one.
                        meas_valid_d  = 1'b1;
                        period_d      = cnt_q;
                        peak_d        = max_q;
                        trough_d      = min_q;
                        amplitude_d   = max_q - min_q;
                        lock_cnt_d    = lock_cnt_meas;
                        locked_d      = (lock_cnt_meas >= LOCK_MAX);
                        prev_period_d = cnt_q;
                        have_prev_d   = 1'b1;
                        cnt_d         = CNT_W'(1);
                        min_d         = sample;
                        max_d         = sample;
                        state_d       = SEEK_ARM;
                    end else begin
                        cnt_d = cnt_inc;
                        if (sample < min_q) min_d = sample;
                        if (sample > max_q) max_d = sample;
                        if (is_arm) state_d = SEEK_CROSS;
                        if (cnt_inc == TIMEOUT_CNT) begin
                            timeout_d   = 1'b1;
                            locked_d    = 1'b0;
                            lock_cnt_d  = '0;
                            have_prev_d = 1'b0;
                            cnt_d       = '0;
                            state_d     = SEEK_ARM0;
                        end
                    end
                end
                default: state_d = SEEK_ARM0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= SEEK_ARM0;
            cnt_q         <= '0;
            min_q         <= '0;
            max_q         <= '0;
            lock_cnt_q    <= '0;
            have_prev_q   <= 1'b0;
            prev_period_q <= '0;
            meas_valid_q  <= 1'b0;
            period_q      <= '0;
            peak_q        <= '0;
            trough_q      <= '0;
            amplitude_q   <= '0;
            locked_q      <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            min_q         <= min_d;
            max_q         <= max_d;
            lock_cnt_q    <= lock_cnt_d;
            have_prev_q   <= have_prev_d;
            prev_period_q <= prev_period_d;
            meas_valid_q  <= meas_valid_d;
            period_q      <= period_d;
            peak_q        <= peak_d;
            trough_q      <= trough_d;
            amplitude_q   <= amplitude_d;
            locked_q      <= locked_d;
            timeout_q     <= timeout_d;
        end
    end

    assign meas_valid = meas_valid_q;
    assign period     = period_q;
    assign peak       = peak_q;
    assign trough     = trough_q;
    assign amplitude  = amplitude_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_adc_sine_monitor.sv
// Bench for adc_sine_monitor: sine/noise/gap stimulus checked every cycle against a
// window-based reference model (queue of samples since the last rising crossing).
module tb_adc_sine_monitor;

    localparam int MID        = 128;
    localparam int HYST       = 4;
    localparam int CNT_W      = 16;
    localparam int TOL        = 2;
    localparam int LOCK_COUNT = 4;
    localparam int TIMEOUT    = 4096;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sample_valid = 1'b0;
    logic [7:0]       sample = 8'd0;
    logic             meas_valid;
    logic [CNT_W-1:0] period;
    logic [7:0]       peak, trough, amplitude;
    logic             locked, timeout;

    adc_sine_monitor #(
        .MID(MID), .HYST(HYST), .CNT_W(CNT_W), .TOL(TOL),
        .LOCK_COUNT(LOCK_COUNT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
        .meas_valid(meas_valid), .period(period), .peak(peak), .trough(trough),
        .amplitude(amplitude), .locked(locked), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: armed/referenced flags plus the list of samples in the open window.
    bit m_ref, m_armed, m_have_prev;
    int m_win[$];
    int m_lock_cnt, m_prev;
    int e_mv, e_period, e_peak, e_trough, e_amp, e_locked, e_to;

    function automatic void model(input bit r, input bit v, input int s);
        e_mv = 0;
        e_to = 0;
        if (r) begin
            m_ref = 0; m_armed = 0; m_have_prev = 0; m_win.delete();
            m_lock_cnt = 0; m_prev = 0;
            e_period = 0; e_peak = 0; e_trough = 0; e_amp = 0; e_locked = 0;
            return;
        end
        if (!v) return;
        if (m_armed && s >= MID + HYST) begin
            if (m_ref) begin
                int mx, mn;
                mx = 0; mn = 255;
                foreach (m_win[k]) begin
                    if (m_win[k] > mx) mx = m_win[k];
                    if (m_win[k] < mn) mn = m_win[k];
                end
                e_mv = 1; e_period = m_win.size(); e_peak = mx; e_trough = mn; e_amp = mx - mn;
                if (!m_have_prev || (e_period - m_prev <= TOL && m_prev - e_period <= TOL))
                    m_lock_cnt = (m_lock_cnt + 1 > LOCK_COUNT) ? LOCK_COUNT : m_lock_cnt + 1;
                else
                    m_lock_cnt = 1;
                m_prev = e_period;
                m_have_prev = 1;
                e_locked = (m_lock_cnt >= LOCK_COUNT);
            end
            m_win.delete();
            m_win.push_back(s);
            m_ref = 1;
            m_armed = 0;
        end else begin
            if (s <= MID - HYST) m_armed = 1;
            if (m_ref) begin
                m_win.push_back(s);
                if (m_win.size() == TIMEOUT) begin
                    e_to = 1; e_locked = 0; m_lock_cnt = 0; m_have_prev = 0;
                    m_ref = 0; m_armed = 0; m_win.delete();
                end
            end
        end
    endfunction

    int sine_tab[256];
    int ph = 0;
    int mv_seen = 0;
    int to_seen = 0;
    int sample_idx = 0;

    task automatic step(input bit r, input bit v, input int s);
        rst = r;
        sample_valid = v;
        sample = 8'(s);
        @(posedge clk);
        #1;
        model(r, v, s);
        check("meas_valid", meas_valid, e_mv);
        check("timeout", timeout, e_to);
        check("locked", locked, e_locked);
        check("period", period, e_period);
        check("peak", peak, e_peak);
        check("trough", trough, e_trough);
        check("amplitude", amplitude, e_amp);
        if (meas_valid) begin
            mv_seen++;
            $display("meas idx=%0d period=%0d peak=%0d trough=%0d amp=%0d locked=%0d",
                     sample_idx, period, peak, trough, amplitude, locked);
        end
        if (timeout) begin
            to_seen++;
            $display("timeout idx=%0d locked=%0d", sample_idx, locked);
        end
        if (v && !r) sample_idx++;
    endtask

    // n valid sine samples; gaps: 0 none, 1 alternate cycles, 2 random; noise adds +/-2.
    task automatic sine_run(input int n, input int stride, input int gaps, input bit noise);
        for (int i = 0; i < n; i++) begin
            int s;
            if (gaps == 1) step(0, 0, $urandom_range(0, 255));
            if (gaps == 2 && $urandom_range(0, 3) == 0) step(0, 0, $urandom_range(0, 255));
            s = sine_tab[ph];
            if (noise) begin
                s = s + $urandom_range(0, 4) - 2;
                if (s < 0) s = 0;
                if (s > 255) s = 255;
            end
            step(0, 1, s);
            ph = (ph + stride) % 256;
        end
    endtask

    task automatic do_reset();
        step(1, $urandom_range(0, 1), $urandom_range(0, 255));
        ph = 0;
        sample_idx = 0;
    endtask

    initial begin
        real two_pi;
        int base, first_period, first_peak, first_trough, first_idx, fourth_locked, fourth_idx;
        two_pi = 6.283185307179586;
        for (int i = 0; i < 256; i++) begin
            real x;
            x = 128.0 + 128.0 * $sin(two_pi * i / 256.0) + 0.5;
            sine_tab[i] = (x > 255.0) ? 255 : $rtoi(x);
        end

        do_reset();
        do_reset();
        check("reset_period", period, 0);
        check("reset_locked", locked, 0);
        check("reset_meas_valid", meas_valid, 0);

        // Continuous 256-sample sine, 9 table passes -> 7 measurements.
        base = mv_seen;
        first_idx = -1; fourth_idx = -1; fourth_locked = 0;
        first_period = 0; first_peak = 0; first_trough = 0;
        for (int i = 0; i < 9 * 256; i++) begin
            sine_run(1, 1, 0, 0);
            if (meas_valid && mv_seen - base == 1) begin
                first_idx = sample_idx - 1; first_period = period;
                first_peak = peak; first_trough = trough;
            end
            if (meas_valid && mv_seen - base == 4) begin
                fourth_idx = sample_idx - 1; fourth_locked = locked;
            end
        end
        check("first_meas_idx", first_idx, 514);
        check("first_period", first_period, 256);
        check("first_peak", first_peak, 255);
        check("first_trough", first_trough, 0);
        check("fourth_meas_idx", fourth_idx, 1282);
        check("fourth_locked", fourth_locked, 1);
        check("meas_count_8p", mv_seen - base, 7);
        check("locked_after_8p", locked, 1);

        // Frequency step to a 128-sample sine.
        base = mv_seen;
        sine_run(8 * 128, 2, 0, 0);
        check("fstep_locked", locked, 1);
        check("fstep_period", period, 128);

        // Timeout while locked.
        base = to_seen;
        for (int i = 0; i < TIMEOUT + 200; i++) step(0, 1, 200);
        check("timeout_count", to_seen - base, 1);
        check("timeout_locked", locked, 0);
        ph = 0;
        sine_run(7 * 256, 1, 0, 0);
        check("relock_after_timeout", locked, 1);

        // Noisy sine with random gaps.
        sine_run(6 * 256, 1, 2, 1);

        // Alternate-cycle valid: period must still be 256.
        base = mv_seen;
        sine_run(5 * 256, 1, 1, 0);
        check("gap_meas_count_min", (mv_seen - base) >= 4, 1);
        check("gap_period", period, 256);
        check("gap_amplitude", amplitude, 255);

        // Reset mid-period, then no measurement before a fresh reference plus a period.
        sine_run(100, 1, 0, 0);
        do_reset();
        check("midrst_locked", locked, 0);
        check("midrst_period", period, 0);
        base = mv_seen;
        sine_run(500, 1, 0, 0);
        check("midrst_no_meas", mv_seen - base, 0);
        sine_run(100, 1, 0, 0);
        check("midrst_meas_after", mv_seen - base, 1);

        // Hysteresis: samples inside the band never arm or cross.
        do_reset();
        base = mv_seen;
        for (int i = 0; i < 1000; i++) step(0, 1, (i % 2 == 0) ? 126 : 130);
        for (int i = 0; i < 300; i++) step(0, 1, 200);
        check("hyst_no_meas", mv_seen - base, 0);
        check("hyst_locked", locked, 0);
        check("hyst_no_timeout", to_seen, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
